// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and the default datapath width
// used by both the subtractor and the serial adder.
package alu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full adder cell; the only arithmetic in the serial adder.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: s1 = (a + b) mod 2^W, ctrl = carry-out, one bit per clock
// LSB-first, with a one-cycle done pulse on completion.
//
// Handshake: start is sampled only while busy=0 (IDLE); an accepted start
// latches a/b, busy rises on that edge, and W edges later done pulses for
// exactly one cycle while busy falls. start during busy is ignored.
module serial_adder
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s1,
    output logic         ctrl
);

    localparam int CW = $clog2(W);
    localparam int PW = W - 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   a_sh_q, a_sh_d;
    logic [W-1:0]   b_sh_q, b_sh_d;
    logic [PW-1:0]  res_q, res_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   s1_q, s1_d;
    logic           ctrl_q, ctrl_d;
    logic           done_q, done_d;

    logic           sum_bit;
    logic           carry_out;
    logic           accept;
    logic           last_bit;

    full_adder_bit u_fa (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (sum_bit),
        .cout (carry_out)
    );

    assign accept   = (state_q == IDLE) && start;
    assign last_bit = (state_q == ADD) && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s1_q    <= '0;
            ctrl_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s1_q    <= s1_d;
            ctrl_q  <= ctrl_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ADD;
            ADD:     if (cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only W-1 partial bits are stored: the final sum bit goes straight into s1,
    // so intermediate partial sums never reach the output.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s1_d    = s1_q;
        ctrl_d  = ctrl_q;
        done_d  = 1'b0;
        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == ADD) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            res_d   = (res_q >> 1) | (PW'(sum_bit) << (PW - 1));
            carry_d = carry_out;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
                s1_d   = {sum_bit, res_q};
                ctrl_d = carry_out;
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        busy = (state_q == ADD);
        done = done_q;
        s1   = s1_q;
        ctrl = ctrl_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder with a scoreboard of
// expected {carry, sum} values.
module tb_serial_adder;

  localparam int W = alu_pkg::ALU_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s1;
  logic         ctrl;

  logic [W:0]   exp_q[$];
  logic [W:0]   last_res;
  int           total = 0;
  int           bad = 0;

  serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s1    (s1),
    .ctrl  (ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after an edge with the DUT idle (or in its done cycle).
  // poke: ADD cycle index at which a spurious start with 1111/1111 is raised.
  // hold: keep start high through the whole operation.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input int poke, input bit hold);
    logic [W:0] e;
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back({1'b0, x} + {1'b0, y});
    step();
    if (!hold) start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("done_low_after_accept", done, 0);
    for (int k = 1; k < W; k++) begin
      if (k == poke) begin
        start = 1'b1;
        a = '1;
        b = '1;
      end else if (!hold) begin
        start = 1'b0;
      end
      step();
      chk("busy_mid", busy, 1);
      chk("done_mid", done, 0);
      chk("result_held_mid", {ctrl, s1}, last_res);
    end
    if (!hold) start = 1'b0;
    step();
    chk("done_at_latency", done, 1);
    chk("busy_low_at_done", busy, 0);
    chk("sb_nonempty", exp_q.size() > 0, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("sum_carry", {ctrl, s1}, e);
    last_res = e;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_done_low", done, 0);
      chk("idle_busy_low", busy, 0);
      chk("idle_result_held", {ctrl, s1}, last_res);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    last_res = '0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_s1", s1, 0);
    chk("reset_ctrl", ctrl, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // 0100 + 0110
    op(4'b0100, 4'b0110, -1, 1'b0);
    idle(1);
    // 1010 + 0110 wraps with carry
    op(4'b1010, 4'b0110, -1, 1'b0);
    idle(2);
    // back-to-back: new start during the done cycle
    op(4'b1111, 4'b1111, -1, 1'b0);
    op(4'b0011, 4'b0100, -1, 1'b0);
    idle(1);
    // start pulsed in 2nd ADD cycle is ignored; no second done
    op(4'b0001, 4'b0001, 2, 1'b0);
    idle(W + 1);

    // asynchronous reset in the middle of an operation
    a = 4'b1010;
    b = 4'b0110;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_s1", s1, 0);
    chk("abort_ctrl", ctrl, 0);
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    step();
    idle(W + 2);
    op(4'b0100, 4'b0110, -1, 1'b0);
    idle(1);

    // exhaustive sweep, alternating 0 and 3 idle cycles between operations
    for (int i = 0; i < 256; i++) begin
      op(W'(i >> 4), W'(i), -1, 1'b0);
      if (i % 2 == 1) idle(3);
    end
    idle(1);

    // start held high continuously
    op(4'b0101, 4'b1001, -1, 1'b1);
    op(4'b1100, 4'b0111, -1, 1'b1);
    op(4'b1111, 4'b0001, -1, 1'b0);
    idle(2);

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
